// File: rtl/coin_scorer.sv
// -----------------------------------------------------------------------------
// coin_scorer
//
// Purpose:
//   Per-frame coin collection and scoring stage. On each frame_tick it takes a
//   snapshot of the three lane coin offsets and the player state. It scans the
//   lanes one per cycle and pulses collect_pulse for each collected coin. It
//   then adds one to a saturating BCD score for each collect, one per cycle,
//   and finally pulses frame_done.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   frame_tick    one-cycle pulse per video frame
//   enable        1 = gameplay active; 0 suppresses collection (rearm still works)
//   player_lane   0 left, 1 middle, 2 right, 3 matches nothing
//   magnet        1 = player matches every lane this frame
//   coin_voffset  lane i signed offset at [i*VWIDTH +: VWIDTH]
//   score_clr     clears the score; wins over a same-cycle increment
//   collect_pulse one-cycle pulse on lane i when its coin is collected
//   score_bcd     BCD score, digit 0 (ones) in [3:0]
//   frame_done    one-cycle pulse when the frame's processing completes
//   busy          high whenever the FSM is not IDLE
//   overrun       sticky; set by a frame_tick that arrives while busy
// -----------------------------------------------------------------------------
module coin_scorer #(
    parameter int VWIDTH = 12,
    parameter int HIT_LO = 180,
    parameter int HIT_HI = 220,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  enable,
    input  logic [1:0]            player_lane,
    input  logic                  magnet,
    input  logic [3*VWIDTH-1:0]   coin_voffset,
    input  logic                  score_clr,
    output logic [2:0]            collect_pulse,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic signed [VWIDTH-1:0] HIT_LO_S = VWIDTH'(HIT_LO);
    localparam logic signed [VWIDTH-1:0] HIT_HI_S = VWIDTH'(HIT_HI);

    // Saturating ripple-carry BCD increment; an all-9s value is returned as-is.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        logic                all9;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*4 +: 4] != 4'd9) begin
                all9 = 1'b0;
            end else begin
                all9 = all9;
            end
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[d*4 +: 4] = v[d*4 +: 4];
            end
        end
        if (all9) begin
            return v;
        end else begin
            return r;
        end
    endfunction

    state_t                   state_r;
    state_t                   state_next_s;
    logic [1:0]               lane_r;
    logic [2:0]               armed_r;
    logic [1:0]               pending_r;
    logic [3*VWIDTH-1:0]      snap_voff_r;
    logic                     snap_enable_r;
    logic [1:0]               snap_lane_r;
    logic                     snap_magnet_r;
    logic [4*DIGITS-1:0]      score_r;
    logic                     overrun_r;

    logic signed [VWIDTH-1:0] voff_s;
    logic [2:0]               lane_mask_s;
    logic                     in_win_s;
    logic                     below_s;
    logic                     match_s;
    logic                     hit_s;

    // Lane evaluation: all decisions use the frame snapshot, never the live inputs.
    always_comb begin
        voff_s = {VWIDTH{1'b0}};
        case (lane_r)
            2'd0:    voff_s = snap_voff_r[0*VWIDTH +: VWIDTH];
            2'd1:    voff_s = snap_voff_r[1*VWIDTH +: VWIDTH];
            2'd2:    voff_s = snap_voff_r[2*VWIDTH +: VWIDTH];
            default: voff_s = {VWIDTH{1'b0}};
        endcase
        lane_mask_s = 3'b001 << lane_r;
        in_win_s    = (voff_s >= HIT_LO_S) && (voff_s <= HIT_HI_S);
        below_s     = (voff_s < HIT_LO_S);
        // lane_r never reaches 3 in SCAN, so player_lane 3 matches nothing.
        match_s     = snap_magnet_r | (snap_lane_r == lane_r);
        hit_s       = (state_r == SCAN) && in_win_s && (|(armed_r & lane_mask_s))
                      && match_s && snap_enable_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_tick) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                // Last lane: the lane-2 collect itself counts toward pending.
                if (lane_r == 2'd2) begin
                    if (hit_s || (pending_r != 2'd0)) begin
                        state_next_s = ADD;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = SCAN;
                end
            end
            ADD: begin
                if (pending_r == 2'd1) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        collect_pulse = 3'b000;
        if (hit_s) begin
            collect_pulse = lane_mask_s;
        end else begin
            collect_pulse = 3'b000;
        end
        frame_done = (state_r == DONE);
        busy       = (state_r != IDLE);
        score_bcd  = score_r;
        overrun    = overrun_r;
    end

    // Snapshot, lane index, arming, pending count, score and overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r        <= 2'd0;
            armed_r       <= 3'b111;
            pending_r     <= 2'd0;
            snap_voff_r   <= {(3*VWIDTH){1'b0}};
            snap_enable_r <= 1'b0;
            snap_lane_r   <= 2'd0;
            snap_magnet_r <= 1'b0;
            score_r       <= {(4*DIGITS){1'b0}};
            overrun_r     <= 1'b0;
        end else begin
            if (frame_tick && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (frame_tick) begin
                        snap_voff_r   <= coin_voffset;
                        snap_enable_r <= enable;
                        snap_lane_r   <= player_lane;
                        snap_magnet_r <= magnet;
                        lane_r        <= 2'd0;
                    end
                end
                SCAN: begin
                    // A coin above the window is a respawn: rearm even if disabled.
                    if (hit_s) begin
                        armed_r   <= armed_r & ~lane_mask_s;
                        pending_r <= pending_r + 2'd1;
                    end else if (below_s) begin
                        armed_r   <= armed_r | lane_mask_s;
                    end
                    lane_r <= lane_r + 2'd1;
                end
                ADD: begin
                    pending_r <= pending_r - 2'd1;
                end
                default: begin
                    lane_r <= lane_r;
                end
            endcase

            if (score_clr) begin
                score_r <= {(4*DIGITS){1'b0}};
            end else if (state_r == ADD) begin
                score_r <= bcd_inc(score_r);
            end
        end
    end

endmodule

// File: tb/tb_coin_scorer.sv
module tb_coin_scorer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        enable;
    logic [1:0]  player_lane;
    logic        magnet;
    logic [35:0] coin_voffset;
    logic        score_clr;
    logic [2:0]  collect_pulse;
    logic [15:0] score_bcd;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    coin_scorer #(.VWIDTH(12), .HIT_LO(180), .HIT_HI(220), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
        .player_lane(player_lane), .magnet(magnet), .coin_voffset(coin_voffset),
        .score_clr(score_clr), .collect_pulse(collect_pulse), .score_bcd(score_bcd),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_off(input int a, input int b, input int c);
        coin_voffset = {12'(c), 12'(b), 12'(a)};
    endtask

    // One full frame with per-lane pulse, latency and score checks.
    task automatic do_frame(input string tag, input int a, input int b, input int c,
                            input logic [2:0] exp_hits, input logic [15:0] exp_score);
        int n;
        int k;
        k = $countones(exp_hits);
        set_off(a, b, c);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int l = 0; l < 3; l++) begin
            check_eq($sformatf("%s_pulse%0d", tag, l), 32'(collect_pulse),
                     exp_hits[l] ? (32'd1 << l) : 32'd0);
            step();
        end
        n = 4;
        while (!frame_done && n < 12) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(4 + k));
        check_eq({tag, "_score"}, 32'(score_bcd), 32'(exp_score));
        step();
        check_eq({tag, "_idle"}, {30'd0, busy, frame_done}, 32'd0);
    endtask

    // Unchecked frame used for bulk scoring; only completion is checked.
    task automatic quiet_frame(input int v);
        int n;
        set_off(v, v, v);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 1;
        while (!frame_done && n < 12) begin
            step();
            n++;
        end
        check_eq("quiet_done", 32'(frame_done), 32'd1);
        step();
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; player_lane = 2'd0;
        magnet = 1'b0; score_clr = 1'b0; coin_voffset = 36'd0;
        step(); step();
        check_eq("rst_outs", {13'd0, collect_pulse, frame_done, busy, overrun, score_bcd}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("rst_idle", {30'd0, busy, frame_done}, 32'd0);

        // Single collect, then disarmed lane, rearm and inclusive lower edge.
        enable = 1'b1; player_lane = 2'd1;
        do_frame("single",  -140,  200, -140, 3'b010, 16'h0001);
        do_frame("disarm",  -140,  200, -140, 3'b000, 16'h0001);
        do_frame("rearm",   -140, -140, -140, 3'b000, 16'h0001);
        do_frame("edge_lo", -140,  180, -140, 3'b010, 16'h0002);
        do_frame("rearm2",  -140, -140, -140, 3'b000, 16'h0002);
        do_frame("above",   -140,  221, -140, 3'b000, 16'h0002);
        do_frame("still_armed", -140, 200, -140, 3'b010, 16'h0003);

        // Preload to 0008, then magnet collect on all three lanes at the upper edge.
        for (int i = 0; i < 5; i++) begin
            do_frame("pre_rearm", -140, -140, -140, 3'b000, 16'(32'h3 + i));
            do_frame("pre_hit",   -140,  200, -140, 3'b010, 16'(32'h4 + i));
        end
        do_frame("mag_rearm", -140, -140, -140, 3'b000, 16'h0008);
        magnet = 1'b1;
        do_frame("magnet", 220, 220, 220, 3'b111, 16'h0011);
        magnet = 1'b0;

        // Suppression: disabled frame leaves lane armed; lane 3 matches nothing.
        do_frame("sup_rearm", -140, -140, -140, 3'b000, 16'h0011);
        enable = 1'b0;
        do_frame("disabled", 200, 200, 200, 3'b000, 16'h0011);
        enable = 1'b1;
        do_frame("armed_kept", 200, 200, 200, 3'b010, 16'h0012);
        player_lane = 2'd3;
        do_frame("lane3", 200, 200, 200, 3'b000, 16'h0012);
        player_lane = 2'd1;

        // score_clr during the first ADD cycle; the remaining two increments still land.
        do_frame("clr_rearm", -140, -140, -140, 3'b000, 16'h0012);
        magnet = 1'b1;
        set_off(200, 200, 200);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step(); step(); step();
        score_clr = 1'b1; step(); score_clr = 1'b0;
        check_eq("clr_prio", 32'(score_bcd), 32'h0000);
        step(); step();
        check_eq("clr_done", 32'(frame_done), 32'd1);
        check_eq("clr_later", 32'(score_bcd), 32'h0002);
        step();
        magnet = 1'b0;

        // Overrun: tick during SCAN is ignored but latched; frame completes normally.
        do_frame("ovr_rearm", -140, -140, -140, 3'b000, 16'h0002);
        set_off(-140, 200, -140);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_eq("ovr_pre", 32'(overrun), 32'd0);
        step();
        check_eq("ovr_pulse", 32'(collect_pulse), 32'h2);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_eq("ovr_set", 32'(overrun), 32'd1);
        step(); step();
        check_eq("ovr_done", 32'(frame_done), 32'd1);
        check_eq("ovr_score", 32'(score_bcd), 32'h0003);
        step(); step();
        check_eq("ovr_sticky", {30'd0, overrun, busy}, 32'd2);

        // Reset during ADD.
        do_frame("rst_rearm", -140, -140, -140, 3'b000, 16'h0003);
        set_off(-140, 200, -140);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step(); step(); step();
        check_eq("add_busy", 32'(busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("rst_add", {13'd0, collect_pulse, frame_done, busy, overrun, score_bcd}, 32'd0);
        step();
        check_eq("rst_add_quiet", {30'd0, busy, frame_done}, 32'd0);

        // Drive score to 9999 with magnet frames, then one more collect saturates.
        magnet = 1'b1;
        for (int i = 0; i < 3333; i++) begin
            quiet_frame(-140);
            quiet_frame(200);
        end
        check_eq("sat_reach", 32'(score_bcd), 32'h9999);
        do_frame("sat_rearm", -140, -140, -140, 3'b000, 16'h9999);
        do_frame("sat_hold", 200, 200, 200, 3'b111, 16'h9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
